// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_bit_timer
//  Purpose  : Receiver bit-timing stage. While enable_timer is held high it
//             issues one shift_strobe at the end of each serial bit period
//             (data bits plus stop bit), then a single packet_done pulse.
//             Dropping enable_timer at any point aborts and clears.
//  Revision : 1.0  - initial release
// ============================================================================
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10,  // clocks per serial bit, 2..1023
  parameter int DATA_BITS    = 8    // data bits per frame, 1..14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_timer,
  output logic       shift_strobe,
  output logic       packet_done,
  output logic [3:0] bit_cnt,
  output logic       busy
);

  // Width just large enough to hold the value CLKS_PER_BIT itself.
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  // Count value one short of a full period: the increment that reaches
  // CNT_FULL is the one that raises the strobe.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 1);
  // bit_cnt value at which the next rollover completes the stop bit.
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;

  // Bit-timing state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= 4'd0;
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Both pulses are single-cycle unless a branch below re-asserts them.
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;

      case (state)
        S_IDLE: begin
          bit_cnt <= 4'd0;
          if (enable_timer) begin
            // The enabling edge itself counts as the first clock of bit 1.
            state   <= S_COUNT;
            clk_cnt <= CNT_ONE;
            busy    <= 1'b1;
          end else begin
            clk_cnt <= '0;
            busy    <= 1'b0;
          end
        end

        S_COUNT: begin
          if (!enable_timer) begin
            // Abort: takes priority even over the final rollover.
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= 4'd0;
            busy    <= 1'b0;
          end else if (clk_cnt == CNT_FULL) begin
            // Bit period rollover: the strobe cycle has just ended.
            clk_cnt <= CNT_ONE;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == BIT_LAST) begin
              state       <= S_DONE;
              packet_done <= 1'b1;
              busy        <= 1'b0;
            end
          end else begin
            clk_cnt      <= clk_cnt + CNT_ONE;
            shift_strobe <= (clk_cnt == CNT_PRE);
          end
        end

        S_DONE: begin
          // Parked until the control unit drops enable_timer, so a held-high
          // enable never starts a second packet.
          busy <= 1'b0;
          if (!enable_timer) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= 4'd0;
          end
        end

        default: begin
          state   <= S_IDLE;
          clk_cnt <= '0;
          bit_cnt <= 4'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
Receiver bit-timing stage that sits directly downstream of the receiver control unit. It consumes enable_timer and produces a one-cycle shift_strobe per bit period for the serial-to-parallel shift register. After the stop bit has been sampled, it raises a one-cycle packet_done back to the control unit. All outputs are registered, and it runs on a single clock domain.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 2..1023.
DATA_BITS, 8, data bits per frame, excluding start and stop bits; legal range 1..14.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset; overrides all other inputs.
enable_timer  input  1  level from the control unit; high = time a packet, low = idle and clear.
shift_strobe  output  1  one-cycle pulse once per bit period, at the end of each bit.
packet_done  output  1  one-cycle pulse after the stop-bit strobe.
bit_cnt  output  4  number of strobes issued in the current packet (0..DATA_BITS+1).
busy  output  1  high while in COUNT.

Behaviour:
- Reset value for all outputs and internal counters is 0, and state is IDLE.
  - Reset is sampled only on a rising clk edge.
  - Reset mid-packet aborts the packet with no packet_done.
- Internal clk_cnt is $clog2(CLKS_PER_BIT+1) bits wide. bit_cnt is 4 bits and never wraps.
- State machine: IDLE, COUNT, DONE.
- IDLE:
  - Edge with enable_timer=1 -> COUNT, clk_cnt<=1, bit_cnt stays 0.
  - Otherwise stay in IDLE.
- COUNT, edge with enable_timer=0:
  - -> IDLE.
  - clk_cnt<=0, bit_cnt<=0, no strobe, no packet_done (abort).
- COUNT, edge with enable_timer=1 and clk_cnt<CLKS_PER_BIT:
  - clk_cnt<=clk_cnt+1.
  - shift_strobe<=1 iff clk_cnt+1==CLKS_PER_BIT, else 0.
- COUNT, edge with enable_timer=1 and clk_cnt==CLKS_PER_BIT:
  - clk_cnt<=1, shift_strobe<=0, bit_cnt<=bit_cnt+1.
  - If bit_cnt+1==DATA_BITS+1 -> DONE and packet_done<=1.
- shift_strobe is high exactly in cycles where clk_cnt==CLKS_PER_BIT.
- Timing from enable_timer first sampled high at edge E0:
  - Strobe k (k=1..DATA_BITS+1) is high in the cycle after edge E0+k*CLKS_PER_BIT-1.
  - packet_done is high in the cycle after edge E0+(DATA_BITS+1)*CLKS_PER_BIT.
  - With defaults, strobes follow E0+9, E0+19, ..., E0+89, and packet_done follows E0+90.
- DONE:
  - packet_done lasts exactly one cycle. shift_strobe=0, bit_cnt holds DATA_BITS+1, busy=0.
  - Stay in DONE while enable_timer=1; no further strobes.
  - enable_timer=0 -> IDLE, bit_cnt<=0.
  - A new packet needs enable_timer low for at least one edge.
- busy is registered, equal to (next state==COUNT).
- shift_strobe and packet_done are never high in the same cycle.
- enable_timer dropping in the same edge as the final bit-period rollover: the abort wins -> IDLE, no packet_done.

Test Plan:
1. rst=1 for 2 cycles with enable_timer=1 -> all outputs 0, state IDLE. Release rst with enable_timer=1 -> first shift_strobe 10 cycles later.
2. Defaults, enable_timer held high from E0 -> 9 strobes at E0+9+10k (k=0..8), bit_cnt 0..9, packet_done one cycle after E0+90, then silent in DONE.
3. Drop enable_timer after strobe 4 -> next edge busy=0, bit_cnt=0, no further strobes, no packet_done. Re-raise -> full 9-strobe packet from scratch.
4. Drop enable_timer at the edge after strobe 9 -> IDLE, packet_done never asserted.
5. CLKS_PER_BIT=2, DATA_BITS=1 -> strobes after E0+1 and E0+3, packet_done after E0+4. Back-to-back packets separated by one low cycle each complete correctly.
6. Assert rst at E0+45 mid-packet -> outputs 0 next cycle. Deassert rst with enable_timer=1 -> timing restarts from the release edge.
